eight_bit_serial_receiver: RTL and testbench



---
 rtl/eight_bit_serial_receiver.sv | 96 +++++++++
 tb/tb_eight_bit_serial_receiver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/eight_bit_serial_receiver.sv
// Serial-to-parallel receiver for the universal shift register link.
// Reassembles LSB- or MSB-first bit streams into words behind a valid/ready handshake.
module eight_bit_serial_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             dir,
  input  logic             sync,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  // state | meaning
  // IDLE  | no partial word, count = 0
  // RECV  | partial word in progress, count = 1..WIDTH-1
  typedef enum logic {IDLE, RECV} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shreg;
  logic             r_dir_q;

  logic             w_accept;
  logic             w_first;
  logic             w_dir_eff;
  logic [CW-1:0]    w_count_base;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_shift;
  logic             w_done;
  logic             w_drop;

  assign w_accept     = enb & sin_valid;
  // sync discards the partial word, so the same edge may start a fresh one
  assign w_first      = sync | (r_state == IDLE);
  assign w_dir_eff    = w_first ? dir : r_dir_q;
  assign w_count_base = w_first ? '0 : r_count;
  assign w_count_nxt  = w_count_base + CW'(1);
  assign w_shift      = w_dir_eff ? {r_shreg[WIDTH-2:0], sin} : {sin, r_shreg[WIDTH-1:1]};
  assign w_done       = w_accept & (w_count_nxt == CW'(WIDTH));
  assign w_drop       = w_done & out_valid & ~out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_shreg   <= '0;
      r_dir_q   <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else if (enb) begin
      if (w_accept) begin
        r_shreg <= w_shift;
        if (w_first) r_dir_q <= dir;
        if (w_done) begin
          r_count <= '0;
          r_state <= IDLE;
          busy    <= 1'b0;
        end else begin
          r_count <= w_count_nxt;
          r_state <= RECV;
          busy    <= 1'b1;
        end
      end else if (sync) begin
        r_count <= '0;
        r_state <= IDLE;
        busy    <= 1'b0;
      end

      if (w_done) begin
        if (!out_valid || out_ready) begin
          out       <= w_shift;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // a drop on the clearing edge keeps the flag set
      if (w_drop)       overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eight_bit_serial_receiver.sv
// Self-checking bench for eight_bit_serial_receiver: directed scenarios plus
// randomized traffic against a queue-based word-assembly model.
module tb_eight_bit_serial_receiver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enb = 1'b0;
  logic         dir = 1'b0;
  logic         sync = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         ovr_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit           m_bits[$];
  bit           m_dir;
  logic [W-1:0] m_out;
  bit           m_valid;
  bit           m_ovr;

  eight_bit_serial_receiver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enb(enb), .dir(dir), .sync(sync), .sin(sin),
    .sin_valid(sin_valid), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_bits.delete();
    m_dir   = 1'b0;
    m_out   = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] word;
    bit done, drop;
    done = 0;
    drop = 0;
    word = '0;
    if (!enb) return;
    if (sync) m_bits.delete();
    if (sin_valid) begin
      if (m_bits.size() == 0) m_dir = dir;
      m_bits.push_back(sin);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          if (m_dir) word[W-1-i] = m_bits[i];
          else       word[i]     = m_bits[i];
        end
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_out   = word;
        m_valid = 1'b1;
      end else begin
        drop = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
  endfunction

  // one clock: inputs are already set, model follows the edge, sample 1 ns later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit e, input bit d, input bit s, input bit b,
                       input bit v, input bit rdy, input bit clr);
    enb = e; dir = d; sync = s; sin = b; sin_valid = v; out_ready = rdy; ovr_clr = clr;
    tick();
  endtask

  function automatic bit bit_of(input logic [W-1:0] word, input int idx, input bit msb_first);
    return msb_first ? word[W-1-idx] : word[idx];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    #1;
    checks++; if (out !== '0)      begin errors++; $display("FAIL reset_out got %h want 00", out); end
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (overrun !== 0)   begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (busy !== 0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] word = 8'h54;
    for (int i = 0; i < W; i++) begin
      drive(1, 0, 0, bit_of(word, i, 0), 1, 0, 0);
      if (i < W - 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL lsb_busy bit %0d got %b want 1", i + 1, busy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lsb_early_valid bit %0d got %b want 0", i + 1, out_valid); end
      end
    end
    checks++; if (out !== 8'h54)      begin errors++; $display("FAIL lsb_out got %h want 54", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL lsb_busy_end got %b want 0", busy); end
    drive(1, 0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lsb_consume got %b want 0", out_valid); end
    checks++; if (out !== 8'h54)      begin errors++; $display("FAIL lsb_out_hold got %h want 54", out); end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] word = 8'hA5;
    for (int i = 0; i < W; i++)
      drive(1, (i == 0) ? 1'b1 : i[0], 0, bit_of(word, i, 1), 1, 0, 0);
    checks++; if (out !== 8'hA5)      begin errors++; $display("FAIL msb_out got %h want a5", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got %b want 1", out_valid); end
    drive(1, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w0 = 8'h3C;
    logic [W-1:0] w1 = 8'hC3;
    for (int i = 0; i < W; i++) drive(1, 0, 0, bit_of(w0, i, 0), 1, 0, 0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_first_ovr got %b want 0", overrun); end
    for (int i = 0; i < W; i++) drive(1, 1, 0, bit_of(w1, i, 1), 1, 0, 0);
    checks++; if (out !== 8'h3C)      begin errors++; $display("FAIL bp_out got %h want 3c", out); end
    checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL bp_ovr got %b want 1", overrun); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
    drive(1, 0, 0, 0, 0, 0, 1);
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL bp_clr got %b want 0", overrun); end
    drive(1, 0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consume got %b want 0", out_valid); end
    // a drop landing on the clearing edge must leave the flag set
    for (int i = 0; i < W; i++) drive(1, 0, 0, bit_of(w0, i, 0), 1, 0, 0);
    for (int i = 0; i < W; i++) drive(1, 0, 0, bit_of(w1, i, 0), 1, 0, (i == W - 1));
    checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL bp_set_wins got %b want 1", overrun); end
    drive(1, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w0 = 8'h11;
    logic [W-1:0] w1 = 8'h22;
    for (int i = 0; i < W; i++) drive(1, 0, 0, bit_of(w0, i, 0), 1, 0, 0);
    checks++; if (out !== 8'h11) begin errors++; $display("FAIL b2b_first got %h want 11", out); end
    for (int i = 0; i < W; i++) drive(1, 0, 0, bit_of(w1, i, 0), 1, (i == W - 1), 0);
    checks++; if (out !== 8'h22)      begin errors++; $display("FAIL b2b_second got %h want 22", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL b2b_ovr got %b want 0", overrun); end
    drive(1, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_sync_gaps();
    logic [W-1:0] word = 8'h81;
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 1, 0, 0);
    drive(1, 0, 1, bit_of(word, 0, 0), 1, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sync_busy got %b want 1", busy); end
    for (int i = 1; i < W; i++) begin
      if (i == 3) drive(0, 1, 1, 1, 1, 1, 1);
      if (i == 5) drive(1, 1, 0, 1, 0, 0, 0);
      drive(1, 1, 0, bit_of(word, i, 0), 1, 0, 0);
    end
    checks++; if (out !== 8'h81)      begin errors++; $display("FAIL sync_out got %h want 81", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sync_valid got %b want 1", out_valid); end
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL enb_freeze got %b want 1", out_valid); end
    drive(1, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 1'($urandom_range(0, 1)), 1, 0, 0);
    rst = 1'b1;
    model_clear();
    #1;
    checks++; if (busy !== 1'b0 || out !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got busy=%b out=%h valid=%b ovr=%b want 0", busy, out, out_valid, overrun);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < W; i++) begin
      drive(1, 0, 0, 1, 1, 0, 0);
      if (i == W - 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early got %b want 0", out_valid); end
      end
    end
    checks++; if (out !== 8'hFF)      begin errors++; $display("FAIL midrst_out got %h want ff", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid got %b want 1", out_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0));
      checks++;
      if (out !== m_out || out_valid !== m_valid || overrun !== m_ovr || busy !== (m_bits.size() != 0)) begin
        errors++;
        $display("FAIL random cyc %0d got out=%h v=%b ovr=%b busy=%b want out=%h v=%b ovr=%b busy=%b",
                 n, out, out_valid, overrun, busy, m_out, m_valid, m_ovr, (m_bits.size() != 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_sync_gaps();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
